// File: rtl/ttl_seq_pkg.sv
// Shared types and sizing for the ttl_74161a counter-chain sequencer.
package ttl_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int DEF_STAGES = 2;
  localparam int DEF_REPW   = 8;

  function automatic int chain_width(input int stages);
    return 4 * stages;
  endfunction

  localparam int DEF_CHAIN_W = chain_width(DEF_STAGES);

endpackage

// File: rtl/ttl_counter_chain_seq_if.sv
// Control bus between the sequencer (master) and a cascade of 161s (slave).
interface ttl_counter_chain_seq_if
  import ttl_seq_pkg::*;
#(
  parameter int W = DEF_CHAIN_W
) ();

  logic         cnt_load_bar;
  logic         cnt_enp;
  logic         cnt_ent;
  logic [W-1:0] cnt_d;
  logic         chain_rco;

  modport master (
    output cnt_load_bar,
    output cnt_enp,
    output cnt_ent,
    output cnt_d,
    input  chain_rco
  );

  modport slave (
    input  cnt_load_bar,
    input  cnt_enp,
    input  cnt_ent,
    input  cnt_d,
    output chain_rco
  );

endinterface

// File: rtl/ttl_74161a.sv
// One 4-bit synchronous binary counter stage with async clear, sync load and RCO.
module ttl_74161a (
  input  logic       Clk,
  input  logic       Clear_bar,
  input  logic       Load_bar,
  input  logic       ENP,
  input  logic       ENT,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       RCO
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Load beats count; counting needs both enables.
  always_comb begin
    q_d = q_q;
    if (!Load_bar) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d = q_q + 4'd1;
    end else begin
      q_d = q_q;
    end
  end

  // Counter register; Clear_bar is the part's asynchronous clear.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q   = q_q;
  assign RCO = ENT && (q_q == 4'hF);

endmodule

// File: rtl/ttl_counter_chain_seq.sv
// Sequencer for a cascade of ttl_74161a counters: preload the chain, run a
// programmable number of reload periods off the last RCO, report busy/tick/done.
module ttl_counter_chain_seq
  import ttl_seq_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int REPW   = DEF_REPW
) (
  input  logic                    Clk,
  input  logic                    Reset_bar,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic [4*STAGES-1:0]     load_val,
  input  logic [REPW-1:0]         reps,
  ttl_counter_chain_seq_if.master chain,
  output logic                    busy,
  output logic                    tick,
  output logic                    done
);

  localparam int              W       = chain_width(STAGES);
  localparam logic [REPW-1:0] REP_ONE = REPW'(1);
  localparam logic [REPW-1:0] REP_MAX = {REPW{1'b1}};

  seq_state_e      state_q, state_d;
  logic [W-1:0]    preload_q, preload_d;
  logic [REPW-1:0] target_q, target_d;
  logic [REPW-1:0] rep_q, rep_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            period_end_s;
  logic            last_period_s;

  // A period ends on an unpaused RUN cycle with the chain at terminal count.
  always_comb begin
    period_end_s  = (state_q == ST_RUN) && chain.chain_rco && !pause;
    last_period_s = (target_q != {REPW{1'b0}}) && (rep_q == (target_q - REP_ONE));
  end

  // Next-state, latched parameters, rep counter and registered pulses.
  always_comb begin
    state_d   = state_q;
    preload_d = preload_q;
    target_d  = target_q;
    rep_d     = rep_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_LOAD;
          preload_d = load_val;
          target_d  = reps;
          rep_d     = {REPW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (period_end_s) begin
          tick_d = 1'b1;
          // Free-run keeps counting periods but must never wrap.
          if (rep_q == REP_MAX) begin
            rep_d = rep_q;
          end else begin
            rep_d = rep_q + REP_ONE;
          end
          if (last_period_s) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Chain controls; load_bar must react to RCO in the same cycle so the
  // chain reloads instead of wrapping, except on the final period.
  always_comb begin
    chain.cnt_ent      = (state_q == ST_RUN);
    chain.cnt_enp      = (state_q == ST_RUN) && !pause;
    chain.cnt_load_bar = !((state_q == ST_LOAD) || (period_end_s && !last_period_s));
    if ((state_q == ST_LOAD) || (state_q == ST_RUN)) begin
      chain.cnt_d = preload_q;
    end else begin
      chain.cnt_d = {W{1'b0}};
    end
  end

  // Sequencer state register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_bar) begin
      state_q   <= ST_IDLE;
      preload_q <= {W{1'b0}};
      target_q  <= {REPW{1'b0}};
      rep_q     <= {REPW{1'b0}};
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preload_q <= preload_d;
      target_q  <= target_d;
      rep_q     <= rep_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign tick = tick_q;
  assign done = done_q;

endmodule

// File: tb/tb_ttl_counter_chain_seq.sv
// Bench: sequencer driving a real two-stage 161 chain, checked every cycle
// against a period-level model plus directed literal expectations.
module tb_ttl_counter_chain_seq;

  localparam int STAGES = 2;
  localparam int REPW   = 8;
  localparam int W      = 4 * STAGES;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic            clk = 1'b0;
  logic            reset_bar = 1'b0;
  logic            clr_n = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            pause = 1'b0;
  logic [W-1:0]    load_val = '0;
  logic [REPW-1:0] reps = '0;
  logic            busy, tick, done;

  logic [STAGES:0] rco_s;
  logic [W-1:0]    q_s;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ttl_counter_chain_seq_if #(.W(W)) cif ();

  ttl_counter_chain_seq #(.STAGES(STAGES), .REPW(REPW)) dut (
    .Clk       (clk),
    .Reset_bar (reset_bar),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .load_val  (load_val),
    .reps      (reps),
    .chain     (cif),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  assign rco_s[0]      = cif.cnt_ent;
  assign cif.chain_rco = rco_s[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_chain
    ttl_74161a u_stage (
      .Clk       (clk),
      .Clear_bar (clr_n),
      .Load_bar  (cif.cnt_load_bar),
      .ENP       (cif.cnt_enp),
      .ENT       (rco_s[k]),
      .D         (cif.cnt_d[4*k +: 4]),
      .Q         (q_s[4*k +: 4]),
      .RCO       (rco_s[k+1])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Period-level model: phase, preload, periods remaining (0 = endless), chain value.
  int           m_phase = P_IDLE;
  int           m_rem = 0;
  logic [W-1:0] m_pre = '0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_qn;
  logic         m_tick = 1'b0;
  logic         m_done = 1'b0;
  logic         m_end;

  logic         e_lb, e_enp, e_ent, e_busy;
  logic [W-1:0] e_d;

  always_comb begin
    e_busy = (m_phase != P_IDLE);
    e_ent  = (m_phase == P_RUN);
    e_enp  = (m_phase == P_RUN) && !pause;
    e_lb   = !((m_phase == P_LOAD) ||
               ((m_phase == P_RUN) && (m_q == ALL1) && !pause && (m_rem != 1)));
    e_d    = ((m_phase == P_LOAD) || (m_phase == P_RUN)) ? m_pre : '0;
  end

  always @(posedge clk) begin
    m_end = (m_phase == P_RUN) && (m_q == ALL1) && !pause;
    if (m_phase == P_LOAD) m_qn = m_pre;
    else if (m_phase == P_RUN && !pause) m_qn = (m_end && m_rem != 1) ? m_pre : m_q + 1'b1;
    else m_qn = m_q;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (!reset_bar) begin
      m_phase = P_IDLE;
      m_rem   = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start && !stop) begin
          m_phase = P_LOAD;
          m_pre   = load_val;
          m_rem   = int'(reps);
        end
        P_LOAD: m_phase = stop ? P_IDLE : P_RUN;
        P_RUN: begin
          if (stop) m_phase = P_IDLE;
          else if (m_end) begin
            m_tick = 1'b1;
            if (m_rem == 1) begin
              m_done  = 1'b1;
              m_phase = P_DONE;
            end else if (m_rem != 0) begin
              m_rem = m_rem - 1;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    m_q = m_qn;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("load_bar", cif.cnt_load_bar, e_lb);
      check("enp", cif.cnt_enp, e_enp);
      check("ent", cif.cnt_ent, e_ent);
      check("cnt_d", cif.cnt_d, e_d);
      check("busy", busy, e_busy);
      check("tick", tick, m_tick);
      check("done", done, m_done);
      check("chain_q", q_s, m_q);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [W-1:0] lv, input logic [REPW-1:0] rp);
    start = 1'b1;
    load_val = lv;
    reps = rp;
    step();
    start = 1'b0;
  endtask

  task automatic run_count(input int n, output int ticks, output int dones, output int first);
    ticks = 0; dones = 0; first = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (tick) begin
        ticks++;
        if (first < 0) first = i;
      end
      if (done) dones++;
    end
  endtask

  task automatic wait_idle(input int budget, output int ticks, output int dones);
    ticks = 0; dones = 0;
    for (int i = 0; i < budget && busy; i++) begin
      step();
      if (tick) ticks++;
      if (done) dones++;
    end
    check("wait_idle_budget", busy, 1'b0);
  endtask

  int tk, dn, ft;

  initial begin
    #1 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_load_bar", cif.cnt_load_bar, 1'b1);
    check("rst_enp", cif.cnt_enp, 1'b0);
    check("rst_ent", cif.cnt_ent, 1'b0);
    check("rst_d", cif.cnt_d, 8'h00);
    reset_bar = 1'b1;
    step();

    // FA x3: 6-cycle periods, ticks at 7/13/19 after LOAD, done with last.
    start_seq(8'hFA, 8'd3);
    check("t1_load_bar", cif.cnt_load_bar, 1'b0);
    check("t1_load_d", cif.cnt_d, 8'hFA);
    run_count(19, tk, dn, ft);
    check("t1_ticks", tk, 3);
    check("t1_first_tick", ft, 7);
    check("t1_dones", dn, 1);
    check("t1_done_last", done, 1'b1);
    check("t1_final_q", q_s, 8'h00);
    step();
    check("t1_busy_drop", busy, 1'b0);

    // Free-run FE: 2-cycle periods; stop on a terminal-count cycle.
    start_seq(8'hFE, 8'd0);
    run_count(22, tk, dn, ft);
    check("t2_ticks", tk, 10);
    check("t2_first_tick", ft, 3);
    check("t2_q_ff", q_s, 8'hFF);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_stop_busy", busy, 1'b0);
    check("t2_stop_tick", tick, 1'b0);
    check("t2_stop_done", done + dn, 0);
    check("t2_stop_enp", cif.cnt_enp, 1'b0);

    // Pause at FF for 4 cycles, then reload F0 and tick once.
    start_seq(8'hF0, 8'd2);
    run_count(16, tk, dn, ft);
    check("t3_at_ff", q_s, 8'hFF);
    pause = 1'b1;
    run_count(4, tk, dn, ft);
    check("t3_pause_ticks", tk, 0);
    check("t3_pause_hold", q_s, 8'hFF);
    pause = 1'b0;
    step();
    check("t3_release_tick", tick, 1'b1);
    check("t3_reload", q_s, 8'hF0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_stop_busy", busy, 1'b0);

    // Reset mid-run at FC, then a clean restart.
    start_seq(8'hFA, 8'd0);
    run_count(3, tk, dn, ft);
    check("t4_q_fc", q_s, 8'hFC);
    reset_bar = 1'b0;
    step();
    reset_bar = 1'b1;
    check("t4_busy", busy, 1'b0);
    check("t4_load_bar", cif.cnt_load_bar, 1'b1);
    check("t4_enp", cif.cnt_enp, 1'b0);
    check("t4_d", cif.cnt_d, 8'h00);
    start_seq(8'hF8, 8'd1);
    step();
    check("t4_reload", q_s, 8'hF8);
    wait_idle(20, tk, dn);
    check("t4_ticks", tk, 1);
    check("t4_dones", dn, 1);

    // start+stop in IDLE is ignored; start during RUN is ignored.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("t5_stay_idle", busy, 1'b0);
    start_seq(8'hFC, 8'd2);
    step();
    start = 1'b1; load_val = 8'h00; reps = 8'd9;
    step();
    start = 1'b0;
    wait_idle(30, tk, dn);
    check("t5_ticks", tk, 2);
    check("t5_dones", dn, 1);

    // All-ones preload: 1-cycle periods, consecutive ticks.
    start_seq(8'hFF, 8'd2);
    step();
    check("t6_c1_q", q_s, 8'hFF);
    check("t6_c1_tick", tick, 1'b0);
    step();
    check("t6_c2_tick", tick, 1'b1);
    check("t6_c2_done", done, 1'b0);
    step();
    check("t6_c3_tick", tick, 1'b1);
    check("t6_c3_done", done, 1'b1);
    check("t6_c3_q", q_s, 8'h00);
    step();
    check("t6_idle", busy, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
